// File: rtl/pattern_match_engine.sv
// Pattern match engine: loads a 5-bit pattern from address 32, counts matches over
// bytes 0..31 (in-byte, per-byte, and across the whole bit stream), writes counts to 33..35.
module pattern_match_engine (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  output logic       halt,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE
  } state_t;

  state_t      state, state_next;
  logic [4:0]  pattern, pattern_next;
  logic [3:0]  prev, prev_next;
  logic [4:0]  idx, idx_next;
  logic [7:0]  ctb, ctb_next;
  logic [7:0]  cto, cto_next;
  logic [7:0]  cts, cts_next;
  logic        halt_next;
  logic [7:0]  addr_next;
  logic        wr_en_next;
  logic [7:0]  wr_data_next;

  logic [11:0] window;
  logic [2:0]  in_cnt;
  logic [2:0]  cross_cnt;

  // Windows [4:0]..[7:3] lie inside the current byte; [8:4]..[11:7] straddle the previous one.
  assign window = {prev, mem_rd_data};

  always_comb begin
    in_cnt    = '0;
    cross_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      if (mem_rd_data[k +: 5] == pattern) in_cnt = in_cnt + 3'd1;
      if (window[k + 4 +: 5] == pattern)  cross_cnt = cross_cnt + 3'd1;
    end
  end

  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    prev_next    = prev;
    idx_next     = idx;
    ctb_next     = ctb;
    cto_next     = cto;
    cts_next     = cts;
    halt_next    = halt;
    addr_next    = mem_addr;
    wr_en_next   = 1'b0;
    wr_data_next = 8'd0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD_PAT;
          addr_next  = 8'd32;
          halt_next  = 1'b0;
        end
      end
      LOAD_PAT: begin
        pattern_next = mem_rd_data[7:3];
        prev_next    = '0;
        idx_next     = '0;
        ctb_next     = '0;
        cto_next     = '0;
        cts_next     = '0;
        halt_next    = 1'b0;
        addr_next    = 8'd0;
        state_next   = SCAN;
      end
      SCAN: begin
        ctb_next  = ctb + {5'd0, in_cnt};
        cto_next  = cto + {7'd0, (in_cnt != 3'd0)};
        // Byte 0 has no predecessor, so only its in-byte windows belong to the stream.
        cts_next  = cts + {5'd0, in_cnt} + ((idx != 5'd0) ? {5'd0, cross_cnt} : 8'd0);
        prev_next = mem_rd_data[3:0];
        if (idx == 5'd31) begin
          state_next   = WR_CTB;
          addr_next    = 8'd33;
          wr_en_next   = 1'b1;
          wr_data_next = ctb_next;
        end else begin
          idx_next  = idx + 5'd1;
          addr_next = {3'd0, idx + 5'd1};
        end
      end
      WR_CTB: begin
        state_next   = WR_CTO;
        addr_next    = 8'd34;
        wr_en_next   = 1'b1;
        wr_data_next = cto;
      end
      WR_CTO: begin
        state_next   = WR_CTS;
        addr_next    = 8'd35;
        wr_en_next   = 1'b1;
        wr_data_next = cts;
      end
      WR_CTS: begin
        state_next = DONE;
        addr_next  = 8'd0;
        halt_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pattern     <= '0;
      prev        <= '0;
      idx         <= '0;
      ctb         <= '0;
      cto         <= '0;
      cts         <= '0;
      halt        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      state       <= state_next;
      pattern     <= pattern_next;
      prev        <= prev_next;
      idx         <= idx_next;
      ctb         <= ctb_next;
      cto         <= cto_next;
      cts         <= cts_next;
      halt        <= halt_next;
      mem_addr    <= addr_next;
      mem_wr_en   <= wr_en_next;
      mem_wr_data <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_pattern_match_engine.sv
// Bench for pattern_match_engine: memory model, bit-stream reference model,
// directed corner cases, reset and restart behaviour, and randomized runs.
module tb_pattern_match_engine;

  logic       CLK;
  logic       Reset;
  logic       start;
  logic       halt;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] core [256];
  logic [7:0] saved [256];
  logic [7:0] logAddr [1024];
  logic [7:0] logData [1024];
  int         wrTotal = 0;
  int         checkCount = 0;
  int         errorCount = 0;

  pattern_match_engine dut (
    .CLK(CLK), .Reset(Reset), .start(start), .halt(halt),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_rd_data = core[mem_addr];

  // Writes are logged here and applied to core by the stimulus process after each run.
  always @(posedge CLK) begin
    if (mem_wr_en && wrTotal < 1024) begin
      logAddr[wrTotal] <= mem_addr;
      logData[wrTotal] <= mem_wr_data;
      wrTotal <= wrTotal + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: treat bytes 0..31 as one 256-bit MSB-first stream and slide a 5-bit window.
  task automatic computeRef(input logic [4:0] pat, output int refCtb, output int refCto, output int refCts);
    logic bits [256];
    int   hitsInByte [32];
    logic [7:0] b;
    logic [4:0] w;
    for (int i = 0; i < 32; i++) begin
      b = core[i];
      hitsInByte[i] = 0;
      for (int m = 0; m < 8; m++) bits[8*i + m] = b[7-m];
    end
    refCtb = 0; refCto = 0; refCts = 0;
    for (int j = 0; j <= 251; j++) begin
      for (int m = 0; m < 5; m++) w[4-m] = bits[j + m];
      if (w == pat) begin
        refCts++;
        if (j % 8 <= 3) begin
          refCtb++;
          hitsInByte[j / 8]++;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hitsInByte[i] > 0) refCto++;
  endtask

  task automatic applyStimulus(input string tag, input bit extraStart);
    int refCtb, refCto, refCts;
    int n;
    int firstLog;
    int diffs;
    logic [7:0] pb;
    pb = core[32];
    computeRef(pb[7:3], refCtb, refCto, refCts);
    for (int i = 0; i < 256; i++) saved[i] = core[i];
    firstLog = wrTotal;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    checkOutput({tag, ":haltDrop"}, halt, 0);
    n = 0;
    while (n < 60) begin
      @(posedge CLK);
      n++;
      #1;
      if (halt) break;
      if (extraStart && n == 10) start = 1'b1;
      if (extraStart && n == 11) start = 1'b0;
    end
    checkOutput({tag, ":latency"}, n, 36);
    checkOutput({tag, ":wrCount"}, wrTotal - firstLog, 3);
    for (int i = firstLog; i < wrTotal; i++) core[logAddr[i]] = logData[i];
    checkOutput({tag, ":ctb"}, core[33], refCtb);
    checkOutput({tag, ":cto"}, core[34], refCto);
    checkOutput({tag, ":cts"}, core[35], refCts);
    diffs = 0;
    for (int i = 0; i < 256; i++)
      if (i < 33 || i > 35) if (core[i] !== saved[i]) diffs++;
    checkOutput({tag, ":untouched"}, diffs, 0);
  endtask

  task automatic fillAll(input logic [7:0] val, input logic [7:0] patByte);
    for (int i = 0; i < 32; i++) core[i] = val;
    core[32] = patByte;
  endtask

  initial begin
    int firstLog;
    for (int i = 0; i < 256; i++) core[i] = 8'hC3;
    Reset = 1'b1;
    start = 1'b0;
    #12;
    checkOutput("rst:halt", halt, 0);
    checkOutput("rst:addr", mem_addr, 0);
    checkOutput("rst:wren", mem_wr_en, 0);
    checkOutput("rst:wdata", mem_wr_data, 0);
    @(negedge CLK);
    Reset = 1'b0;

    fillAll(8'h55, 8'hA8);
    applyStimulus("alt", 1'b0);
    checkOutput("alt:ctbConst", core[33], 64);
    checkOutput("alt:ctoConst", core[34], 32);
    checkOutput("alt:ctsConst", core[35], 126);

    fillAll(8'hFF, 8'hF8);
    applyStimulus("ones", 1'b0);
    checkOutput("ones:ctsConst", core[35], 252);
    fillAll(8'hFF, 8'h00);
    applyStimulus("zeroPat", 1'b0);

    fillAll(8'h00, 8'hE0);
    core[0] = 8'h07;
    applyStimulus("cross", 1'b0);
    checkOutput("cross:ctsConst", core[35], 1);

    // Reset in the middle of SCAN (index 10)
    fillAll(8'h55, 8'hA8);
    firstLog = wrTotal;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (11) @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    checkOutput("midRst:halt", halt, 0);
    checkOutput("midRst:wren", mem_wr_en, 0);
    checkOutput("midRst:addr", mem_addr, 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    checkOutput("midRst:noWrites", wrTotal - firstLog, 0);
    checkOutput("midRst:haltIdle", halt, 0);
    for (int i = 33; i < 36; i++) core[i] = 8'hC3;
    applyStimulus("afterRst", 1'b0);

    fillAll(8'h3C, 8'h78);
    applyStimulus("dupStart", 1'b1);

    for (int t = 0; t < 100; t++) begin
      logic [7:0] mask;
      mask = 8'($urandom);
      for (int i = 0; i < 32; i++) core[i] = 8'($urandom) & mask;
      core[32] = 8'($urandom);
      applyStimulus("rand", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pattern_match_engine.md
PATTERN_MATCH_ENGINE -- requirements
Module: pattern_match_engine

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request pulse from host; sampled on rising CLK.
REQ-004 SHALL have port halt, output, 1 bit: done/ack to host; registered.
REQ-005 SHALL have port mem_addr, output, 8 bits: data-memory address; registered.
REQ-006 SHALL have port mem_rd_data, input, 8 bits: data-memory read data; combinational read, valid in the same cycle as mem_addr.
REQ-007 SHALL have port mem_wr_en, output, 1 bit: data-memory write strobe; write commits at the next rising CLK.
REQ-008 SHALL have port mem_wr_data, output, 8 bits: data-memory write data.

Function
REQ-009 SHALL implement states IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
REQ-010 SHALL move IDLE->LOAD_PAT, and DONE->LOAD_PAT, on an edge sampling start=1; start in any other state SHALL be ignored.
REQ-011 SHALL, in LOAD_PAT, drive mem_addr=32, latch pattern = mem_rd_data[7:3] at the next edge, clear all counters, clear halt, and enter SCAN with byte index 0.
REQ-012 SHALL, in SCAN, drive mem_addr=index (0..31), process one byte per cycle, and enter WR_CTB after index 31.
REQ-013 SHALL increment ctb once per match of pattern against byte[4:0], [5:1], [6:2], [7:3] (0-4 per byte).
REQ-014 SHALL increment cto by 1 for each byte with at least one in-byte match.
REQ-015 SHALL compute cts over the 256-bit stream (byte 0 most significant, MSB first): byte 0 contributes its 4 in-byte windows; byte i>0 contributes 8 windows of {prev[3:0], byte}: bits [11:7] down to [4:0]; 252 windows total.
REQ-016 SHALL hold ctb, cto, cts as 8-bit counters; maximums 128, 32, 252, so no wrap occurs.
REQ-017 SHALL keep a 4-bit prev register, loaded with byte[3:0] each SCAN cycle.
REQ-018 SHALL, in WR_CTB, WR_CTO and WR_CTS, assert mem_wr_en for one cycle each with mem_addr/mem_wr_data = 33/ctb, 34/cto, 35/cts.
REQ-019 SHALL deassert mem_wr_en in every other state.
REQ-020 SHALL set halt=1 on entering DONE and hold it until a new start is accepted.
REQ-021 SHALL have fixed latency: with start sampled at edge 0, halt goes high after edge 36, and the last memory write commits at edge 36.
REQ-022 SHALL leave data memory unmodified except addresses 33-35.

Reset
REQ-023 SHALL, on Reset=1 at any time including mid-SCAN or mid-write, immediately force state=IDLE, halt=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counters=0, prev=0, pattern=0.
REQ-024 SHALL perform no memory write after Reset asserts; a subsequent start SHALL yield correct results.

Verification
REQ-025 SHALL pass: core[0..31]=0x55, core[32]=0xA8 (pattern 10101), start pulse -> core[33]=64, core[34]=32, core[35]=126, with halt high 36 edges after start.
REQ-026 SHALL pass: core[0..31]=0xFF, pattern 11111 (core[32]=0xF8) -> 128, 32, 252; with pattern 00000 -> 0, 0, 0.
REQ-027 SHALL pass: core[0]=0x07, core[1..31]=0x00, pattern 11100 (core[32]=0xE0) -> ctb=0, cto=0, cts=1 (byte-crossing only).
REQ-028 SHALL pass: Reset pulsed at SCAN index 10 -> halt=0, no writes to 33-35; a following start gives correct results.
REQ-029 SHALL pass: a second start during SCAN is ignored, so timing and results are unchanged; a start while in DONE drops halt and reruns correctly.
REQ-030 SHALL pass: 100 random pattern and byte sets compared against a reference model for all three counts.
